l15_anycore_resp_queue: RTL and testbench

- Parametrised successor to the L1.5-to-anycore response encoder.
- Decodes L1.5 return packets and buffers icache fills and dcache load fills in per-channel FIFOs with valid/ready handshakes toward the core.
- Generates registered store-complete and wakeup-interrupt pulses.
- Tracks outstanding dcache loads and stores with counters that drive a stall, instead of single-bit idle/active flags.
- Sits between the L1.5 output bus and the anycore memory interface, inside the tile.

---
 rtl/l15_anycore_resp_queue_if.sv | 43 ++++
 rtl/l15_anycore_resp_queue.sv | 178 +++++++++++++++++
 tb/tb_l15_anycore_resp_queue.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l15_anycore_resp_queue_if.sv
// rtl/l15_anycore_resp_queue_if.sv - L1.5 response bus and anycore fill/counter handshake bundle
interface l15_anycore_resp_queue_if #(
   parameter int PADDR_W  = 40,
   parameter int IC_WORDS = 4,
   parameter int DC_WORDS = 2
);
   logic                     l15_val;
   logic [3:0]               l15_returntype;
   logic [PADDR_W-1:0]       l15_address;
   logic [63:0]              l15_data_0;
   logic [63:0]              l15_data_1;
   logic [63:0]              l15_data_2;
   logic [63:0]              l15_data_3;
   logic                     req_ack;
   logic                     ic_valid;
   logic                     ic_ready;
   logic [PADDR_W-1:0]       ic_addr;
   logic [IC_WORDS*64-1:0]   ic_data;
   logic                     dc_valid;
   logic                     dc_ready;
   logic [PADDR_W-1:0]       dc_addr;
   logic [DC_WORDS*64-1:0]   dc_data;
   logic                     dc_ld_req;
   logic                     dc_st_req;
   logic                     dc_stall;
   logic                     st_complete;
   logic                     anycore_int;
   logic                     proto_err;

   modport master (
      output l15_val, l15_returntype, l15_address, l15_data_0, l15_data_1, l15_data_2, l15_data_3,
      output ic_ready, dc_ready, dc_ld_req, dc_st_req,
      input  req_ack, ic_valid, ic_addr, ic_data, dc_valid, dc_addr, dc_data,
      input  dc_stall, st_complete, anycore_int, proto_err
   );

   modport slave (
      input  l15_val, l15_returntype, l15_address, l15_data_0, l15_data_1, l15_data_2, l15_data_3,
      input  ic_ready, dc_ready, dc_ld_req, dc_st_req,
      output req_ack, ic_valid, ic_addr, ic_data, dc_valid, dc_addr, dc_data,
      output dc_stall, st_complete, anycore_int, proto_err
   );
endinterface

// File: rtl/l15_anycore_resp_queue.sv
// rtl/l15_anycore_resp_queue.sv - L1.5 response decoder with per-channel fill FIFOs and outstanding-request stall
module l15_anycore_resp_queue_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_push,
   input  logic [W-1:0] i_wdata,
   input  logic         i_pop,
   output logic         o_full,
   output logic         o_empty,
   output logic [W-1:0] o_rdata
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wp;
   logic [PW-1:0] r_rp;
   logic          w_do_push;
   logic          w_do_pop;

   // Extra pointer bit distinguishes full from empty when the index bits match.
   assign o_empty   = (r_wp == r_rp);
   assign o_full    = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
   assign o_rdata   = r_mem[r_rp[AW-1:0]];
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wp <= '0;
         r_rp <= '0;
      end else begin
         if (w_do_push) r_wp <= r_wp + PTR_ONE;
         if (w_do_pop)  r_rp <= r_rp + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wp[AW-1:0]] <= i_wdata;
   end
endmodule

module l15_anycore_resp_queue #(
   parameter int PADDR_W         = 40,
   parameter int IC_WORDS        = 4,
   parameter int DC_WORDS        = 2,
   parameter int FIFO_DEPTH      = 2,
   parameter int MAX_OUTSTANDING = 2,
   parameter bit BYTE_SWAP       = 1'b1
) (
   input  logic                              clk,
   input  logic                              rst_n,
   l15_anycore_resp_queue_if.slave           bus
);
   localparam logic [3:0] LOAD_RET  = 4'b0000;
   localparam logic [3:0] IFILL_RET = 4'b0001;
   localparam logic [3:0] ST_ACK    = 4'b0100;
   localparam logic [3:0] INT_RET   = 4'b0111;
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam int SW = CW + 1;
   localparam int IW = PADDR_W + IC_WORDS * 64;
   localparam int DW = PADDR_W + DC_WORDS * 64;
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   function automatic logic [63:0] f_swap(input logic [63:0] w);
      logic [63:0] r;
      for (int j = 0; j < 8; j++) r[8*(7-j) +: 8] = w[8*j +: 8];
      return r;
   endfunction

   logic [63:0]          w_word [4];
   logic [IC_WORDS*64-1:0] w_ic_line;
   logic [DC_WORDS*64-1:0] w_dc_line;
   logic                 w_is_ifill, w_is_load, w_is_st, w_is_int;
   logic                 w_ic_full, w_ic_empty, w_dc_full, w_dc_empty;
   logic                 w_ic_push, w_dc_push, w_ic_pop, w_dc_pop;
   logic [IW-1:0]        w_ic_head;
   logic [DW-1:0]        w_dc_head;
   logic                 w_ack, w_st_acc, w_int_acc;
   logic [SW-1:0]        w_sum;
   logic                 w_stall, w_one_left;
   logic                 w_drop_stall, w_drop_pair;
   logic                 w_ld_inc, w_st_inc, w_ld_under, w_st_under;
   logic [CW-1:0]        r_ld_cnt, r_st_cnt;
   logic                 r_st_complete, r_anycore_int, r_proto_err;

   always_comb begin
      w_word[0] = BYTE_SWAP ? f_swap(bus.l15_data_0) : bus.l15_data_0;
      w_word[1] = BYTE_SWAP ? f_swap(bus.l15_data_1) : bus.l15_data_1;
      w_word[2] = BYTE_SWAP ? f_swap(bus.l15_data_2) : bus.l15_data_2;
      w_word[3] = BYTE_SWAP ? f_swap(bus.l15_data_3) : bus.l15_data_3;
      w_ic_line = '0;
      w_dc_line = '0;
      for (int k = 0; k < IC_WORDS; k++) w_ic_line[64*k +: 64] = w_word[k];
      for (int k = 0; k < DC_WORDS; k++) w_dc_line[64*k +: 64] = w_word[k];
   end

   assign w_is_ifill = (bus.l15_returntype == IFILL_RET);
   assign w_is_load  = (bus.l15_returntype == LOAD_RET);
   assign w_is_st    = (bus.l15_returntype == ST_ACK);
   assign w_is_int   = (bus.l15_returntype == INT_RET);

   // Fill acks look only at registered full, so a same-cycle pop never frees a slot early.
   assign w_ack     = bus.l15_val && (w_is_ifill ? !w_ic_full : (w_is_load ? !w_dc_full : 1'b1));
   assign w_ic_push = bus.l15_val && w_is_ifill && !w_ic_full;
   assign w_dc_push = bus.l15_val && w_is_load && !w_dc_full;
   assign w_st_acc  = bus.l15_val && w_is_st;
   assign w_int_acc = bus.l15_val && w_is_int && (bus.l15_data_0[17:16] == 2'b01);
   assign w_ic_pop  = !w_ic_empty && bus.ic_ready;
   assign w_dc_pop  = !w_dc_empty && bus.dc_ready;

   l15_anycore_resp_queue_fifo #(.W(IW), .DEPTH(FIFO_DEPTH)) u_ic_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_ic_push),
      .i_wdata ({bus.l15_address, w_ic_line}),
      .i_pop   (w_ic_pop),
      .o_full  (w_ic_full),
      .o_empty (w_ic_empty),
      .o_rdata (w_ic_head)
   );

   l15_anycore_resp_queue_fifo #(.W(DW), .DEPTH(FIFO_DEPTH)) u_dc_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_dc_push),
      .i_wdata ({bus.l15_address, w_dc_line}),
      .i_pop   (w_dc_pop),
      .o_full  (w_dc_full),
      .o_empty (w_dc_empty),
      .o_rdata (w_dc_head)
   );

   assign w_sum        = {1'b0, r_ld_cnt} + {1'b0, r_st_cnt};
   assign w_stall      = (w_sum >= SW'(MAX_OUTSTANDING));
   assign w_one_left   = (w_sum == SW'(MAX_OUTSTANDING - 1));
   assign w_drop_stall = w_stall && (bus.dc_ld_req || bus.dc_st_req);
   // Two requests racing for the last slot are both rejected rather than arbitrated.
   assign w_drop_pair  = !w_stall && bus.dc_ld_req && bus.dc_st_req && w_one_left;
   assign w_ld_inc     = bus.dc_ld_req && !w_stall && !w_drop_pair;
   assign w_st_inc     = bus.dc_st_req && !w_stall && !w_drop_pair;
   assign w_ld_under   = w_dc_pop && !w_ld_inc && (r_ld_cnt == '0);
   assign w_st_under   = w_st_acc && !w_st_inc && (r_st_cnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ld_cnt      <= '0;
         r_st_cnt      <= '0;
         r_st_complete <= 1'b0;
         r_anycore_int <= 1'b0;
         r_proto_err   <= 1'b0;
      end else begin
         if (w_ld_inc && !w_dc_pop)                         r_ld_cnt <= r_ld_cnt + CNT_ONE;
         else if (!w_ld_inc && w_dc_pop && r_ld_cnt != '0)  r_ld_cnt <= r_ld_cnt - CNT_ONE;
         if (w_st_inc && !w_st_acc)                         r_st_cnt <= r_st_cnt + CNT_ONE;
         else if (!w_st_inc && w_st_acc && r_st_cnt != '0)  r_st_cnt <= r_st_cnt - CNT_ONE;
         r_st_complete <= w_st_acc;
         r_anycore_int <= w_int_acc;
         r_proto_err   <= r_proto_err || w_drop_stall || w_drop_pair || w_ld_under || w_st_under;
      end
   end

   assign bus.req_ack     = w_ack;
   assign bus.ic_valid    = !w_ic_empty;
   assign bus.ic_addr     = w_ic_head[IW-1 -: PADDR_W];
   assign bus.ic_data     = w_ic_head[IC_WORDS*64-1:0];
   assign bus.dc_valid    = !w_dc_empty;
   assign bus.dc_addr     = w_dc_head[DW-1 -: PADDR_W];
   assign bus.dc_data     = w_dc_head[DC_WORDS*64-1:0];
   assign bus.dc_stall    = w_stall;
   assign bus.st_complete = r_st_complete;
   assign bus.anycore_int = r_anycore_int;
   assign bus.proto_err   = r_proto_err;
endmodule

// File: tb/tb_l15_anycore_resp_queue.sv
// tb/tb_l15_anycore_resp_queue.sv - directed scoreboard bench for l15_anycore_resp_queue
module tb_l15_anycore_resp_queue;
   localparam logic [3:0] T_LOAD  = 4'b0000;
   localparam logic [3:0] T_IFILL = 4'b0001;
   localparam logic [3:0] T_ST    = 4'b0100;
   localparam logic [3:0] T_INT   = 4'b0111;

   logic clk;
   logic rst_n;
   int   vecs;
   int   errs;
   logic [303:0] ic_q[$];
   logic [303:0] dc_q[$];
   logic [255:0] line;

   l15_anycore_resp_queue_if #(.PADDR_W(40), .IC_WORDS(4), .DC_WORDS(2)) bus ();

   l15_anycore_resp_queue #(
      .PADDR_W(40), .IC_WORDS(4), .DC_WORDS(2), .FIFO_DEPTH(2), .MAX_OUTSTANDING(2), .BYTE_SWAP(1'b1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] rev8(input logic [63:0] w);
      logic [63:0] r;
      r = {<<8{w}};
      return r;
   endfunction

   function automatic logic [255:0] model_line(input int words, input logic [63:0] d0);
      logic [63:0] d [4];
      logic [255:0] l;
      d[0] = d0;
      d[1] = ~d0;
      d[2] = d0 ^ 64'hA5A5_5A5A_0F0F_F0F0;
      d[3] = {d0[31:0], d0[63:32]};
      l = '0;
      for (int k = 0; k < words; k++) l[64*k +: 64] = rev8(d[k]);
      return l;
   endfunction

   task automatic chk(input string tag, input logic [303:0] obs, input logic [303:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic send(input logic [3:0] t, input logic [39:0] a, input logic [63:0] d0);
      bus.l15_val        = 1'b1;
      bus.l15_returntype = t;
      bus.l15_address    = a;
      bus.l15_data_0     = d0;
      bus.l15_data_1     = ~d0;
      bus.l15_data_2     = d0 ^ 64'hA5A5_5A5A_0F0F_F0F0;
      bus.l15_data_3     = {d0[31:0], d0[63:32]};
   endtask

   task automatic exp_ic(input logic [39:0] a, input logic [63:0] d0);
      line = model_line(4, d0);
      ic_q.push_back({a, line});
   endtask

   task automatic exp_dc(input logic [39:0] a, input logic [63:0] d0);
      line = model_line(2, d0);
      dc_q.push_back({a, line[127:0]});
   endtask

   task automatic pop_ic();
      chk("ic_valid_at_pop", bus.ic_valid, 1'b1);
      if (ic_q.size() == 0) chk("ic_queue_nonempty", 1'b0, 1'b1);
      else chk("ic_head", {bus.ic_addr, bus.ic_data}, ic_q.pop_front());
      bus.ic_ready = 1'b1;
      tick();
      bus.ic_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.l15_val = 1'b0; bus.l15_returntype = '0; bus.l15_address = '0;
      bus.l15_data_0 = '0; bus.l15_data_1 = '0; bus.l15_data_2 = '0; bus.l15_data_3 = '0;
      bus.ic_ready = 1'b0; bus.dc_ready = 1'b0; bus.dc_ld_req = 1'b0; bus.dc_st_req = 1'b0;
      ic_q.delete();
      dc_q.delete();
      tick();
      tick();
      chk("rst_ic_valid", bus.ic_valid, 1'b0);
      chk("rst_dc_valid", bus.dc_valid, 1'b0);
      chk("rst_dc_stall", bus.dc_stall, 1'b0);
      chk("rst_st_complete", bus.st_complete, 1'b0);
      chk("rst_anycore_int", bus.anycore_int, 1'b0);
      chk("rst_proto_err", bus.proto_err, 1'b0);
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      vecs = 0;
      errs = 0;
      do_reset();

      // byte-swapped icache fill, same-cycle ack, 1-cycle latency
      send(T_IFILL, 40'h10_0000_0040, 64'h0123456789ABCDEF);
      settle();
      chk("ifill_ack", bus.req_ack, 1'b1);
      exp_ic(40'h10_0000_0040, 64'h0123456789ABCDEF);
      tick();
      bus.l15_val = 1'b0;
      chk("ifill_visible", bus.ic_valid, 1'b1);
      chk("ifill_swap_w0", bus.ic_data[63:0], 64'hEFCDAB8967452301);
      pop_ic();
      settle();
      chk("ic_empty_after_pop", bus.ic_valid, 1'b0);

      // FIFO full backpressure, no full-bypass, order preserved
      send(T_IFILL, 40'h00_0000_1000, 64'h1111_2222_3333_4444);
      settle();
      chk("bp_ack1", bus.req_ack, 1'b1);
      exp_ic(40'h00_0000_1000, 64'h1111_2222_3333_4444);
      tick();
      send(T_IFILL, 40'h00_0000_2000, 64'h5555_6666_7777_8888);
      settle();
      chk("bp_ack2", bus.req_ack, 1'b1);
      exp_ic(40'h00_0000_2000, 64'h5555_6666_7777_8888);
      tick();
      send(T_IFILL, 40'h00_0000_3000, 64'h9999_AAAA_BBBB_CCCC);
      settle();
      chk("bp_ack3_full", bus.req_ack, 1'b0);
      tick();
      chk("bp_ack3_held", bus.req_ack, 1'b0);
      chk("bp_head_first", {bus.ic_addr, bus.ic_data}, ic_q.pop_front());
      bus.ic_ready = 1'b1;
      settle();
      chk("bp_no_bypass", bus.req_ack, 1'b0);
      tick();
      bus.ic_ready = 1'b0;
      settle();
      chk("bp_ack3_after_pop", bus.req_ack, 1'b1);
      exp_ic(40'h00_0000_3000, 64'h9999_AAAA_BBBB_CCCC);
      tick();
      bus.l15_val = 1'b0;
      pop_ic();
      pop_ic();
      settle();
      chk("bp_drained", bus.ic_valid, 1'b0);

      // outstanding counters and stall
      do_reset();
      bus.dc_ld_req = 1'b1;
      tick();
      bus.dc_ld_req = 1'b0;
      chk("stall_after_ld", bus.dc_stall, 1'b0);
      bus.dc_st_req = 1'b1;
      tick();
      bus.dc_st_req = 1'b0;
      chk("stall_after_ld_st", bus.dc_stall, 1'b1);
      chk("no_err_yet", bus.proto_err, 1'b0);
      bus.dc_ld_req = 1'b1;
      tick();
      bus.dc_ld_req = 1'b0;
      chk("err_req_in_stall", bus.proto_err, 1'b1);
      chk("ld_cnt_dropped", dut.r_ld_cnt, 2'd1);
      send(T_ST, 40'h0, 64'h0);
      settle();
      chk("st_ack_ack", bus.req_ack, 1'b1);
      tick();
      bus.l15_val = 1'b0;
      chk("st_complete_pulse", bus.st_complete, 1'b1);
      chk("stall_released", bus.dc_stall, 1'b0);
      tick();
      chk("st_complete_one_cycle", bus.st_complete, 1'b0);

      // dcache fill and coincident ld_req + pop
      send(T_LOAD, 40'h20_0000_0080, 64'hDEAD_BEEF_CAFE_F00D);
      settle();
      chk("load_ack", bus.req_ack, 1'b1);
      exp_dc(40'h20_0000_0080, 64'hDEAD_BEEF_CAFE_F00D);
      tick();
      bus.l15_val = 1'b0;
      chk("dc_valid", bus.dc_valid, 1'b1);
      chk("dc_head", {bus.dc_addr, bus.dc_data}, dc_q.pop_front());
      bus.dc_ready = 1'b1;
      bus.dc_ld_req = 1'b1;
      tick();
      bus.dc_ready = 1'b0;
      bus.dc_ld_req = 1'b0;
      chk("ld_cnt_inc_dec", dut.r_ld_cnt, 2'd1);
      chk("dc_empty", bus.dc_valid, 1'b0);

      // ST_ACK with nothing outstanding
      do_reset();
      send(T_ST, 40'h0, 64'h0);
      tick();
      bus.l15_val = 1'b0;
      chk("st_cnt_saturate", dut.r_st_cnt, 2'd0);
      chk("err_st_underflow", bus.proto_err, 1'b1);
      chk("st_complete_underflow", bus.st_complete, 1'b1);

      // both requests racing for the last slot
      do_reset();
      bus.dc_ld_req = 1'b1;
      tick();
      bus.dc_st_req = 1'b1;
      tick();
      bus.dc_ld_req = 1'b0;
      bus.dc_st_req = 1'b0;
      chk("pair_ld_cnt", dut.r_ld_cnt, 2'd1);
      chk("pair_st_cnt", dut.r_st_cnt, 2'd0);
      chk("pair_err", bus.proto_err, 1'b1);

      // wakeup interrupt decode
      do_reset();
      send(T_INT, 40'h0, 64'h0000_0000_0001_0000);
      settle();
      chk("int_ack", bus.req_ack, 1'b1);
      tick();
      bus.l15_val = 1'b0;
      chk("int_pulse", bus.anycore_int, 1'b1);
      tick();
      chk("int_one_cycle", bus.anycore_int, 1'b0);
      send(T_INT, 40'h0, 64'h0000_0000_0002_0000);
      settle();
      chk("int_other_ack", bus.req_ack, 1'b1);
      tick();
      bus.l15_val = 1'b0;
      chk("int_other_no_pulse", bus.anycore_int, 1'b0);
      send(4'b1111, 40'h0, 64'h0);
      settle();
      chk("unknown_ack", bus.req_ack, 1'b1);
      tick();
      bus.l15_val = 1'b0;
      chk("unknown_no_err", bus.proto_err, 1'b0);

      // asynchronous reset with both FIFOs occupied
      do_reset();
      send(T_IFILL, 40'h30_0000_0000, 64'h0F1E_2D3C_4B5A_6978);
      tick();
      send(T_LOAD, 40'h31_0000_0000, 64'h8796_A5B4_C3D2_E1F0);
      tick();
      bus.l15_val = 1'b0;
      bus.dc_ld_req = 1'b1;
      bus.dc_st_req = 1'b1;
      tick();
      bus.dc_ld_req = 1'b0;
      bus.dc_st_req = 1'b0;
      chk("pre_rst_ic_valid", bus.ic_valid, 1'b1);
      chk("pre_rst_dc_valid", bus.dc_valid, 1'b1);
      chk("pre_rst_stall", bus.dc_stall, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_ic_valid", bus.ic_valid, 1'b0);
      chk("async_dc_valid", bus.dc_valid, 1'b0);
      chk("async_dc_stall", bus.dc_stall, 1'b0);
      ic_q.delete();
      dc_q.delete();
      send(T_IFILL, 40'h32_0000_0040, 64'h0011_2233_4455_6677);
      tick();
      rst_n = 1'b1;
      settle();
      chk("pending_ack", bus.req_ack, 1'b1);
      exp_ic(40'h32_0000_0040, 64'h0011_2233_4455_6677);
      tick();
      bus.l15_val = 1'b0;
      pop_ic();

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
